// File: rtl/ram_march_bist.sv
// ram_march_bist: March C- self-test initiator for a 16x8 synchronous RAM
module ram_march_bist #(
  parameter logic [7:0] PATTERN = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [3:0] fail_addr,
  output logic [7:0] fail_data,
  output logic       ram_we,
  output logic       ram_re,
  output logic [3:0] ram_waddr,
  output logic [3:0] ram_raddr,
  output logic [7:0] ram_din,
  input  logic [7:0] ram_dout
);
  typedef enum logic [3:0] {IDLE, M0, M1, M2, M3, M4, M5, CHK, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] addr_q, addr_d, fa_q, fa_d, waddr_q, raddr_q;
  logic [4:0] err_q, err_d;
  logic [7:0] fd_q, fd_d, din_q, din_d;
  logic ph_q, ph_d, pass_q, pass_d, we_q, we_d, re_q, re_d;
  logic two, desc, last, run, cmp, mis, two_d, act_d;
  logic [7:0] exp_v;
  // next-state sequencing, read-data compare and registered RAM drive values
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    ph_d = ph_q;
    two = state_q inside {M1, M2, M3, M4};
    desc = state_q inside {M3, M4};
    last = desc ? addr_q == 4'd0 : addr_q == 4'd15;
    run = state_q == IDLE && start;
    if (run) begin
      state_d = M0;
      addr_d = 4'd0;
      ph_d = 1'b0;
    end else if (state_q == CHK) state_d = DONE;
    else if (state_q == DONE) state_d = IDLE;
    else if (state_q != IDLE) begin
      if (two && !ph_q) ph_d = 1'b1;
      else begin
        ph_d = 1'b0;
        if (last) begin
          state_d = state_t'(state_q + 4'd1);
          addr_d = state_q inside {M2, M3} ? 4'd15 : 4'd0;
        end else addr_d = desc ? addr_q - 4'd1 : addr_q + 4'd1;
      end
    end
    cmp = (two && ph_q) || (state_q == M5 && addr_q != 4'd0) || state_q == CHK;
    exp_v = state_q inside {M2, M4} ? ~PATTERN : PATTERN;
    mis = cmp && ram_dout != exp_v;
    err_d = run ? 5'd0 : (mis && err_q != 5'd31) ? err_q + 5'd1 : err_q;
    fa_d = run ? 4'd0 : (mis && err_q == 5'd0) ? (two ? addr_q : addr_q - 4'd1) : fa_q;
    fd_d = run ? 8'd0 : (mis && err_q == 5'd0) ? ram_dout : fd_q;
    pass_d = run ? 1'b0 : state_d == DONE ? err_d == 5'd0 : pass_q;
    two_d = state_d inside {M1, M2, M3, M4};
    act_d = state_d inside {M0, M1, M2, M3, M4, M5};
    we_d = state_d == M0 || (two_d && ph_d);
    re_d = state_d == M5 || (two_d && !ph_d);
    din_d = !we_d ? 8'd0 : state_d inside {M1, M3} ? ~PATTERN : PATTERN;
  end
  // state, result and RAM-port registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= 4'd0;
      ph_q <= 1'b0;
      err_q <= 5'd0;
      fa_q <= 4'd0;
      fd_q <= 8'd0;
      pass_q <= 1'b0;
      we_q <= 1'b0;
      re_q <= 1'b0;
      waddr_q <= 4'd0;
      raddr_q <= 4'd0;
      din_q <= 8'd0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      ph_q <= ph_d;
      err_q <= err_d;
      fa_q <= fa_d;
      fd_q <= fd_d;
      pass_q <= pass_d;
      we_q <= we_d;
      re_q <= re_d;
      waddr_q <= act_d ? addr_d : 4'd0;
      raddr_q <= act_d ? addr_d : 4'd0;
      din_q <= din_d;
    end
  end
  assign busy = state_q inside {M0, M1, M2, M3, M4, M5, CHK};
  assign done = state_q == DONE;
  assign pass = pass_q;
  assign err_count = err_q;
  assign fail_addr = fa_q;
  assign fail_data = fd_q;
  assign ram_we = we_q;
  assign ram_re = re_q;
  assign ram_waddr = waddr_q;
  assign ram_raddr = raddr_q;
  assign ram_din = din_q;
endmodule

// File: tb/tb_ram_march_bist.sv
// tb_ram_march_bist: directed checks of the March C- BIST against RAM models
module tb_ram_march_bist;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic busy0, done0, pass0, we0, re0, busy1, done1, pass1, we1, re1;
  logic [4:0] err0, err1;
  logic [3:0] fa0, fa1, wa0, ra0, wa1, ra1;
  logic [7:0] fd0, fd1, din0, din1, dout0, dout1;
  logic [7:0] mem0 [16];
  logic [7:0] mem1 [16];
  int checks = 0, failures = 0, mode = 0, lat;
  logic [3:0] raddr_log [200];
  logic re_log [200], busy_log [200], we1_log [200];
  logic [7:0] din1_log [200];

  always #5 clk = ~clk;

  ram_march_bist #(.PATTERN(8'h00)) u0 (.clk(clk), .rst(rst), .start(start), .busy(busy0),
    .done(done0), .pass(pass0), .err_count(err0), .fail_addr(fa0), .fail_data(fd0),
    .ram_we(we0), .ram_re(re0), .ram_waddr(wa0), .ram_raddr(ra0), .ram_din(din0), .ram_dout(dout0));
  ram_march_bist #(.PATTERN(8'hA5)) u1 (.clk(clk), .rst(rst), .start(start), .busy(busy1),
    .done(done1), .pass(pass1), .err_count(err1), .fail_addr(fa1), .fail_data(fd1),
    .ram_we(we1), .ram_re(re1), .ram_waddr(wa1), .ram_raddr(ra1), .ram_din(din1), .ram_dout(dout1));

  initial for (int i = 0; i < 16; i++) begin mem0[i] = 8'h00; mem1[i] = 8'h00; end

  // RAM 0: mode 0 ideal, mode 1 bit 3 of word 5 stuck at 1, mode 2 reads always 8'hFF
  always @(posedge clk) begin
    if (we0) mem0[wa0] <= din0;
    else if (re0) dout0 <= mode == 2 ? 8'hFF : (mode == 1 && ra0 == 4'd5) ? (mem0[ra0] | 8'h08) : mem0[ra0];
    else mem0[wa0] <= mem0[ra0];
  end
  // RAM 1: always ideal
  always @(posedge clk) begin
    if (we1) mem1[wa1] <= din1;
    else if (re1) dout1 <= mem1[ra1];
    else mem1[wa1] <= mem1[ra1];
  end

  // port protocol: never we&re, and waddr==raddr whenever we=0
  always @(negedge clk) if (!rst && busy0) begin
    checks++;
    if ((we0 && re0) || (!we0 && wa0 != ra0)) begin
      failures++;
      $display("FAIL protocol we=%b re=%b waddr=%0d raddr=%0d", we0, re0, wa0, ra0);
    end
  end

  task automatic run(input int rst_at, input int restart_at, output int l);
    l = -1;
    repeat (2) @(posedge clk);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 0; n < 200; n++) begin
      raddr_log[n] = ra0; re_log[n] = re0; busy_log[n] = busy0;
      we1_log[n] = we1; din1_log[n] = din1;
      if (done0) begin l = n; break; end
      if (n == rst_at) begin
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        break;
      end
      @(negedge clk) start = (n == restart_at);
      @(posedge clk);
      #1 start = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy0, done0, pass0, err0, fa0, fd0, we0, re0, wa0, ra0, din0} !== 38'd0) begin
      failures++;
      $display("FAIL reset_u0 got %h want 0", {busy0, done0, pass0, err0, fa0, fd0, we0, re0, wa0, ra0, din0});
    end
    checks++;
    if ({busy1, done1, pass1, err1, we1, re1, din1} !== 16'd0) begin
      failures++;
      $display("FAIL reset_u1 got %h want 0", {busy1, done1, pass1, err1, we1, re1, din1});
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_clean;
    logic ok;
    mode = 0;
    run(-1, -1, lat);
    checks++;
    if (lat !== 161) begin failures++; $display("FAIL clean_latency got %0d want 161", lat); end
    checks++;
    if (pass0 !== 1'b1 || err0 !== 5'd0) begin
      failures++; $display("FAIL clean_result pass=%b err=%0d want pass=1 err=0", pass0, err0);
    end
    checks++;
    if (busy_log[0] !== 1'b1 || busy_log[160] !== 1'b1 || busy0 !== 1'b0) begin
      failures++; $display("FAIL clean_busy c0=%b c160=%b c161=%b want 1 1 0", busy_log[0], busy_log[160], busy0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done0 !== 1'b0) begin failures++; $display("FAIL done_width got %b want 0", done0); end
    ok = 1'b1;
    for (int i = 0; i < 16; i++) if (mem0[i] !== 8'h00) ok = 1'b0;
    checks++;
    if (!ok) begin failures++; $display("FAIL clean_mem got nonzero word want all 00"); end
  endtask

  task automatic test_descending;
    checks++;
    if (re_log[80] !== 1'b1 || raddr_log[80] !== 4'd15) begin
      failures++; $display("FAIL desc_c80 re=%b addr=%0d want re=1 addr=15", re_log[80], raddr_log[80]);
    end
    checks++;
    if (re_log[110] !== 1'b1 || raddr_log[110] !== 4'd0) begin
      failures++; $display("FAIL desc_c110 re=%b addr=%0d want re=1 addr=0", re_log[110], raddr_log[110]);
    end
    checks++;
    if (re_log[16] !== 1'b1 || raddr_log[16] !== 4'd0) begin
      failures++; $display("FAIL first_read re=%b addr=%0d want re=1 addr=0", re_log[16], raddr_log[16]);
    end
  endtask

  task automatic test_pattern;
    checks++;
    if (din1_log[0] !== 8'hA5 || we1_log[0] !== 1'b1) begin
      failures++; $display("FAIL pat_m0_write got we=%b din=%h want 1 a5", we1_log[0], din1_log[0]);
    end
    checks++;
    if (din1_log[17] !== 8'h5A || we1_log[17] !== 1'b1) begin
      failures++; $display("FAIL pat_m1_write got we=%b din=%h want 1 5a", we1_log[17], din1_log[17]);
    end
    checks++;
    if (pass1 !== 1'b1 || err1 !== 5'd0) begin
      failures++; $display("FAIL pat_result pass=%b err=%0d want pass=1 err=0", pass1, err1);
    end
  endtask

  task automatic test_stuck;
    mode = 1;
    run(-1, -1, lat);
    checks++;
    if (lat !== 161) begin failures++; $display("FAIL stuck_latency got %0d want 161", lat); end
    checks++;
    if (pass0 !== 1'b0 || err0 !== 5'd3) begin
      failures++; $display("FAIL stuck_count pass=%b err=%0d want pass=0 err=3", pass0, err0);
    end
    checks++;
    if (fa0 !== 4'd5 || fd0 !== 8'h08) begin
      failures++; $display("FAIL stuck_first addr=%0d data=%h want 5 08", fa0, fd0);
    end
  endtask

  task automatic test_reset_mid;
    mode = 0;
    run(70, -1, lat);
    checks++;
    if ({busy0, done0, err0, we0, re0, wa0, ra0, din0} !== 27'd0) begin
      failures++; $display("FAIL mid_reset got %h want 0", {busy0, done0, err0, we0, re0, wa0, ra0, din0});
    end
    run(-1, -1, lat);
    checks++;
    if (lat !== 161 || pass0 !== 1'b1) begin
      failures++; $display("FAIL mid_rerun latency=%0d pass=%b want 161 1", lat, pass0);
    end
  endtask

  task automatic test_saturate;
    mode = 2;
    run(-1, 50, lat);
    checks++;
    if (lat !== 161) begin failures++; $display("FAIL sat_latency got %0d want 161", lat); end
    checks++;
    if (err0 !== 5'd31 || pass0 !== 1'b0) begin
      failures++; $display("FAIL sat_count err=%0d pass=%b want 31 0", err0, pass0);
    end
    checks++;
    if (fa0 !== 4'd0 || fd0 !== 8'hFF) begin
      failures++; $display("FAIL sat_first addr=%0d data=%h want 0 ff", fa0, fd0);
    end
  endtask

  initial begin
    test_reset;
    test_clean;
    test_descending;
    test_pattern;
    test_stuck;
    test_reset_mid;
    test_saturate;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
